// File: rtl/alu_regfile_exec.sv
// Single-cycle register-execute datapath: 32x32 register file feeding a 32-bit ALU.
// One MIPS-style instruction per cycle; the write and the result report happen at the same edge.
module alu_regfile_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        overflow,
  output logic        illegal
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // Entry 0 is cleared by reset and never written, but reads of r0 are forced to zero anyway.
  logic [31:0] rf_q [32];

  logic [31:0] rs_val, rt_val, simm, zimm;
  logic [31:0] sum_rr, sum_ri, diff;

  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'h0000, imm};
  assign sum_rr = rs_val + rt_val;
  assign sum_ri = rs_val + simm;
  assign diff   = rs_val - rt_val;

  logic [31:0] alu_res;
  logic [4:0]  wr_addr;
  logic        legal;
  logic        ovf;

  always_comb begin
    alu_res = '0;
    wr_addr = rt;
    legal   = 1'b1;
    ovf     = 1'b0;
    if (opcode == OpRtype) begin
      wr_addr = rd;
      case (funct)
        FnSll:  alu_res = rt_val << shamt;
        FnSrl:  alu_res = rt_val >> shamt;
        FnSra:  alu_res = $signed(rt_val) >>> shamt;
        FnAdd: begin
          alu_res = sum_rr;
          ovf     = (rs_val[31] == rt_val[31]) && (sum_rr[31] != rs_val[31]);
        end
        FnAddu: alu_res = sum_rr;
        FnSub: begin
          alu_res = diff;
          ovf     = (rs_val[31] != rt_val[31]) && (diff[31] != rs_val[31]);
        end
        FnSubu: alu_res = diff;
        FnAnd:  alu_res = rs_val & rt_val;
        FnOr:   alu_res = rs_val | rt_val;
        FnXor:  alu_res = rs_val ^ rt_val;
        FnNor:  alu_res = ~(rs_val | rt_val);
        FnSlt:  alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
        FnSltu: alu_res = {31'b0, rs_val < rt_val};
        default: legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        OpAddi: begin
          alu_res = sum_ri;
          ovf     = (rs_val[31] == simm[31]) && (sum_ri[31] != rs_val[31]);
        end
        OpAddiu: alu_res = sum_ri;
        OpSlti:  alu_res = {31'b0, $signed(rs_val) < $signed(simm)};
        OpSltiu: alu_res = {31'b0, rs_val < simm};
        OpAndi:  alu_res = rs_val & zimm;
        OpOri:   alu_res = rs_val | zimm;
        OpXori:  alu_res = rs_val ^ zimm;
        OpLui:   alu_res = {imm, 16'h0000};
        default: legal = 1'b0;
      endcase
    end
  end

  logic [31:0] result_q;
  logic        result_valid_q, overflow_q, illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      illegal_q      <= 1'b0;
      if (instr_valid) begin
        if (legal) begin
          if (wr_addr != 5'd0) rf_q[wr_addr] <= alu_res;
          // Report what the destination actually holds, so r0 reads back as zero.
          result_q       <= (wr_addr == 5'd0) ? '0 : alu_res;
          result_valid_q <= 1'b1;
          overflow_q     <= ovf;
        end else begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  assign dbg_data     = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_regfile_exec.sv
// Randomized bench for alu_regfile_exec against an arithmetic reference model of the register file,
// with directed instructions whose results are pinned to literal values.
module tb_alu_regfile_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] result;
  logic        result_valid;
  logic        overflow;
  logic        illegal;

  alu_regfile_exec dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mreg [32];
  logic [31:0] exp_result;
  bit          exp_rv, exp_ovf, exp_ill;
  bit          check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    exp_result = '0;
    exp_rv     = 1'b0;
    exp_ovf    = 1'b0;
    exp_ill    = 1'b0;
  endtask

  // Reference semantics using wide signed arithmetic rather than bit-level overflow rules.
  task automatic model_exec(input logic [31:0] ins, output bit legal, output int unsigned dst,
                            output logic [31:0] val, output bit ovf);
    logic [31:0] a, b, simm, zimm;
    longint      sa, sb, si, s;
    int unsigned sh;
    a    = mreg[ins[25:21]];
    b    = mreg[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    si   = longint'($signed(simm));
    sh   = int'(ins[10:6]);
    legal = 1'b1;
    ovf   = 1'b0;
    val   = '0;
    dst   = int'(ins[20:16]);
    s     = 0;
    if (ins[31:26] == 6'h00) begin
      dst = int'(ins[15:11]);
      case (ins[5:0])
        6'h00: val = b << sh;
        6'h02: val = b >> sh;
        6'h03: begin s = sb >>> sh; val = s[31:0]; end
        6'h20, 6'h21: begin
          s = sa + sb; val = s[31:0];
          ovf = (ins[5:0] == 6'h20) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        6'h22, 6'h23: begin
          s = sa - sb; val = s[31:0];
          ovf = (ins[5:0] == 6'h22) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        6'h24: val = a & b;
        6'h25: val = a | b;
        6'h26: val = a ^ b;
        6'h27: val = ~(a | b);
        6'h2A: val = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: val = (a < b) ? 32'd1 : 32'd0;
        default: legal = 1'b0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h09: begin
          s = sa + si; val = s[31:0];
          ovf = (ins[31:26] == 6'h08) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        6'h0A: val = (sa < si) ? 32'd1 : 32'd0;
        6'h0B: val = (a < simm) ? 32'd1 : 32'd0;
        6'h0C: val = a & zimm;
        6'h0D: val = a | zimm;
        6'h0E: val = a ^ zimm;
        6'h0F: val = {ins[15:0], 16'h0000};
        default: legal = 1'b0;
      endcase
    end
  endtask

  // Called just after a rising edge: apply an instruction, let the next edge take it, update model.
  task automatic step(input logic [31:0] ins, input bit v);
    bit          lg, ov;
    int unsigned d;
    logic [31:0] val;
    instr       = ins;
    instr_valid = v;
    model_exec(ins, lg, d, val, ov);
    @(posedge clk);
    #1;
    exp_rv  = 1'b0;
    exp_ovf = 1'b0;
    exp_ill = 1'b0;
    if (v) begin
      if (lg) begin
        if (d != 0) mreg[d] = val;
        exp_result = (d == 0) ? 32'd0 : val;
        exp_rv     = 1'b1;
        exp_ovf    = ov;
      end else begin
        exp_ill = 1'b1;
      end
    end
    dbg_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    chk(name, dbg_data, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] rand_instr();
    int unsigned k;
    logic [4:0]  a, b, d, sh;
    logic [15:0] im;
    logic [5:0]  fn, op;
    k  = $urandom_range(0, 9);
    a  = 5'($urandom_range(0, 15));
    b  = 5'($urandom_range(0, 15));
    d  = 5'($urandom_range(0, 15));
    sh = 5'($urandom_range(0, 31));
    im = 16'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: im = 16'h0000;
        1: im = 16'h7FFF;
        2: im = 16'h8000;
        default: im = 16'hFFFF;
      endcase
    end
    if (k < 5) begin
      case ($urandom_range(0, 13))
        0: fn = 6'h00;  1: fn = 6'h02;  2: fn = 6'h03;  3: fn = 6'h20;
        4: fn = 6'h21;  5: fn = 6'h22;  6: fn = 6'h23;  7: fn = 6'h24;
        8: fn = 6'h25;  9: fn = 6'h26;  10: fn = 6'h27; 11: fn = 6'h2A;
        12: fn = 6'h2B;
        default: fn = ($urandom_range(0, 1) == 0) ? 6'h01 : 6'h3F;
      endcase
      return rtype(a, b, d, sh, fn);
    end else if (k < 9) begin
      op = 6'h08 + 6'($urandom_range(0, 7));
      return itype(op, a, b, im);
    end else begin
      op = 6'($urandom_range(16, 63));
      return itype(op, a, b, im);
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("result", result, exp_result);
      chk_bit("result_valid", result_valid, exp_rv);
      chk_bit("overflow", overflow, exp_ovf);
      chk_bit("illegal", illegal, exp_ill);
      chk("dbg_data", dbg_data, mreg[dbg_addr]);
    end
  end

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;
    model_reset();
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("reset_dbg_sweep", dbg_data, 32'd0);
    end
    chk("reset_result", result, 32'd0);
    chk_bit("reset_result_valid", result_valid, 1'b0);
    chk_bit("reset_overflow", overflow, 1'b0);
    chk_bit("reset_illegal", illegal, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    step(itype(6'h0D, 5'd0, 5'd1, 16'h003C), 1'b1);
    chk("ori_r1", result, 32'd60);
    dbg_chk("dbg_r1", 5'd1, 32'd60);
    step(itype(6'h0D, 5'd0, 5'd2, 16'h0028), 1'b1);
    chk("ori_r2", result, 32'd40);
    step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1'b1);
    chk("add_r3", result, 32'd100);
    chk_bit("add_valid", result_valid, 1'b1);
    step(32'd0, 1'b0);
    chk_bit("valid_pulse_end", result_valid, 1'b0);
    step(rtype(5'd2, 5'd1, 5'd4, 5'd0, 6'h22), 1'b1);
    chk("sub_r4", result, 32'hFFFFFFEC);
    step(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h24), 1'b1);
    chk("and", result, 32'h28);
    step(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h25), 1'b1);
    chk("or", result, 32'h3C);
    step(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h27), 1'b1);
    chk("nor", result, 32'hFFFFFFC3);
    step(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h26), 1'b1);
    chk("xor", result, 32'h14);
    step(rtype(5'd4, 5'd1, 5'd5, 5'd0, 6'h2A), 1'b1);
    chk("slt", result, 32'd1);
    step(rtype(5'd4, 5'd1, 5'd5, 5'd0, 6'h2B), 1'b1);
    chk("sltu", result, 32'd0);
    step(rtype(5'd0, 5'd4, 5'd14, 5'd2, 6'h03), 1'b1);
    chk("sra", result, 32'hFFFFFFFB);
    step(rtype(5'd0, 5'd4, 5'd15, 5'd2, 6'h02), 1'b1);
    chk("srl", result, 32'h3FFFFFFB);
    step(itype(6'h0F, 5'd0, 5'd6, 16'h8000), 1'b1);
    chk("lui_r6", result, 32'h80000000);
    step(itype(6'h0F, 5'd0, 5'd7, 16'h7FFF), 1'b1);
    step(itype(6'h0D, 5'd7, 5'd7, 16'hFFFF), 1'b1);
    chk("r7_max", result, 32'h7FFFFFFF);
    step(itype(6'h08, 5'd7, 5'd8, 16'h0001), 1'b1);
    chk("addi_wrap", result, 32'h80000000);
    chk_bit("addi_overflow", overflow, 1'b1);
    step(itype(6'h09, 5'd7, 5'd8, 16'h0001), 1'b1);
    chk("addiu_wrap", result, 32'h80000000);
    chk_bit("addiu_no_overflow", overflow, 1'b0);
    step(itype(6'h3F, 5'd1, 5'd8, 16'h1234), 1'b1);
    chk_bit("illegal_flag", illegal, 1'b1);
    chk_bit("illegal_no_valid", result_valid, 1'b0);
    chk("illegal_result_hold", result, 32'h80000000);
    dbg_chk("illegal_no_write", 5'd8, 32'h80000000);
    step(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 1'b1);
    chk("add_r0_result", result, 32'd0);
    dbg_chk("dbg_r0", 5'd0, 32'd0);
    step(itype(6'h08, 5'd0, 5'd9, 16'd5), 1'b1);
    step(rtype(5'd9, 5'd9, 5'd9, 5'd0, 6'h20), 1'b1);
    chk("back_to_back", result, 32'd10);

    // Reset with a write to r1 pending: nothing must land, and clearing needs no edge.
    instr       = itype(6'h0D, 5'd0, 5'd1, 16'h1234);
    instr_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    dbg_addr = 5'd1;
    #1;
    chk("async_clear_r1", dbg_data, 32'd0);
    chk("async_clear_result", result, 32'd0);
    @(posedge clk);
    #2;
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("aborted_write_r1", dbg_data, 32'd0);
    chk_bit("aborted_write_valid", result_valid, 1'b0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      step(rand_instr(), $urandom_range(0, 99) < 85);
    end
    step(32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
